// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter (shift-and-add-3) with valid/ready on both sides.
// Optional two's-complement input, sticky overflow and significant-digit count.
module bin2bcd_stream #(
  parameter int BINARY_BITS = 16,
  parameter int BCD_DIGITS  = 5,
  parameter bit SIGNED      = 1'b0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BINARY_BITS-1:0]             binary_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [4*BCD_DIGITS-1:0]            bcd_out,
  output logic                               sign_out,
  output logic                               overflow,
  output logic [$clog2(BCD_DIGITS+1)-1:0]    num_digits
);

  localparam int DW    = 4 * BCD_DIGITS;
  localparam int ND_W  = $clog2(BCD_DIGITS + 1);
  localparam int CNT_W = $clog2(BINARY_BITS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]             state;
  logic [BINARY_BITS-1:0] shift_reg;
  logic [DW-1:0]          digits;
  logic [CNT_W-1:0]       count;
  logic                   ovf_acc;
  logic                   sign_r;
  logic [ND_W-1:0]        nd_r;

  logic                   accept;
  logic                   last_shift;
  logic                   negative;
  logic [BINARY_BITS-1:0] magnitude;
  logic [DW-1:0]          adjusted;
  logic [DW-1:0]          next_digits;
  logic                   carry_out;
  logic [ND_W-1:0]        nd_next;

  assign in_ready   = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_shift = (count == CNT_W'(BINARY_BITS - 1));

  // The most negative input negates to itself, which read unsigned is the right magnitude.
  assign negative  = SIGNED & binary_in[BINARY_BITS-1];
  assign magnitude = negative ? ((~binary_in) + BINARY_BITS'(1)) : binary_in;

  always_comb begin
    adjusted = digits;
    for (int j = 0; j < BCD_DIGITS; j++) begin
      if (digits[4*j +: 4] >= 4'd5) begin
        adjusted[4*j +: 4] = digits[4*j +: 4] + 4'd3;
      end
    end
    {carry_out, next_digits} = {adjusted, shift_reg[BINARY_BITS-1]};
  end

  always_comb begin
    nd_next = ND_W'(1);
    for (int j = 0; j < BCD_DIGITS; j++) begin
      if (next_digits[4*j +: 4] != 4'd0) begin
        nd_next = ND_W'(j + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      digits    <= '0;
      count     <= '0;
      ovf_acc   <= 1'b0;
      sign_r    <= 1'b0;
      nd_r      <= '0;
    end else if (accept) begin
      state     <= SHIFT;
      shift_reg <= magnitude;
      digits    <= '0;
      count     <= '0;
      ovf_acc   <= 1'b0;
      sign_r    <= negative;
    end else begin
      case (state)
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          digits    <= next_digits;
          ovf_acc   <= ovf_acc | carry_out;
          count     <= count + CNT_W'(1);
          if (last_shift) begin
            state <= HOLD;
            nd_r  <= nd_next;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = (state == HOLD);
  assign bcd_out    = digits;
  assign sign_out   = sign_r;
  assign overflow   = ovf_acc;
  assign num_digits = nd_r;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: three configurations driven in lockstep from shared inputs,
// checked against a decimal arithmetic model through a scoreboard queue.
module tb_bin2bcd_stream;

  typedef struct packed {
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
    logic [2:0]  nd;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
    exp_t c;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] binary_in;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, sign_a, ovf_a;
  logic [19:0] bcd_a;
  logic [2:0]  nd_a;
  logic        in_ready_b, out_valid_b, sign_b, ovf_b;
  logic [15:0] bcd_b;
  logic [2:0]  nd_b;
  logic        in_ready_c, out_valid_c, sign_c, ovf_c;
  logic [19:0] bcd_c;
  logic [2:0]  nd_c;

  int   compared   = 0;
  int   mismatched = 0;
  txn_t sb[$];
  exp_t hold_exp;

  always #5 clock = ~clock;

  bin2bcd_stream #(.BINARY_BITS(16), .BCD_DIGITS(5), .SIGNED(1'b0)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .binary_in(binary_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .bcd_out(bcd_a), .sign_out(sign_a), .overflow(ovf_a), .num_digits(nd_a));

  bin2bcd_stream #(.BINARY_BITS(16), .BCD_DIGITS(4), .SIGNED(1'b0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .binary_in(binary_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .bcd_out(bcd_b), .sign_out(sign_b), .overflow(ovf_b), .num_digits(nd_b));

  bin2bcd_stream #(.BINARY_BITS(16), .BCD_DIGITS(5), .SIGNED(1'b1)) dut_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
    .binary_in(binary_in), .out_valid(out_valid_c), .out_ready(out_ready),
    .bcd_out(bcd_c), .sign_out(sign_c), .overflow(ovf_c), .num_digits(nd_c));

  function automatic exp_t model(input logic [15:0] v, input bit sgn, input int ndig);
    exp_t e;
    int   mag;
    int   lim;
    int   m;
    int   d;
    e   = '0;
    mag = int'(v);
    if (sgn && v[15]) begin
      mag    = 65536 - mag;
      e.sign = 1'b1;
    end
    lim = 1;
    for (int j = 0; j < ndig; j++) lim = lim * 10;
    e.ovf = (mag >= lim);
    m     = mag % lim;
    e.nd  = 3'd1;
    for (int j = 0; j < ndig; j++) begin
      d = m % 10;
      e.bcd[4*j +: 4] = 4'(d);
      if (d != 0) e.nd = 3'(j + 1);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    txn_t t;
    t.a = model(v, 1'b0, 5);
    t.b = model(v, 1'b0, 4);
    t.c = model(v, 1'b1, 5);
    sb.push_back(t);
    binary_in = v;
    in_valid  = 1'b1;
  endtask

  task automatic compare_result();
    txn_t t;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    t = sb.pop_front();
    checkOutput("a_bcd",  32'(bcd_a),  32'(t.a.bcd));
    checkOutput("a_sign", 32'(sign_a), 32'(t.a.sign));
    checkOutput("a_ovf",  32'(ovf_a),  32'(t.a.ovf));
    checkOutput("a_nd",   32'(nd_a),   32'(t.a.nd));
    checkOutput("b_bcd",  32'(bcd_b),  32'(t.b.bcd));
    checkOutput("b_ovf",  32'(ovf_b),  32'(t.b.ovf));
    checkOutput("b_nd",   32'(nd_b),   32'(t.b.nd));
    checkOutput("c_bcd",  32'(bcd_c),  32'(t.c.bcd));
    checkOutput("c_sign", 32'(sign_c), 32'(t.c.sign));
    checkOutput("c_ovf",  32'(ovf_c),  32'(t.c.ovf));
    checkOutput("c_nd",   32'(nd_c),   32'(t.c.nd));
  endtask

  // Counts edges until out_valid rises; a negative exp_lat skips the latency check.
  task automatic wait_result(input int exp_lat);
    int n;
    n = 0;
    while (out_valid_a !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (out_valid_a !== 1'b1) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_lat >= 0) checkOutput("latency", 32'(n), 32'(exp_lat));
    checkOutput("b_valid", 32'(out_valid_b), 32'd1);
    checkOutput("c_valid", 32'(out_valid_c), 32'd1);
    compare_result();
  endtask

  initial begin
    logic [15:0] vals [5];
    vals = '{16'd12345, 16'd9999, 16'h8000, 16'h7FFF, 16'h0001};

    reset     = 1'b1;
    in_valid  = 1'b0;
    binary_in = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_ready", 32'(in_ready_a), 32'd1);
    checkOutput("rst_bcd",   32'(bcd_a), 32'd0);
    checkOutput("rst_nd",    32'(nd_a), 32'd0);
    checkOutput("rst_sign",  32'(sign_c), 32'd0);
    checkOutput("rst_ovf",   32'(ovf_b), 32'd0);

    $display("[TB] full-scale conversion and latency");
    applyStimulus(16'd65535);
    tick();
    in_valid = 1'b0;
    checkOutput("shift_in_ready", 32'(in_ready_a), 32'd0);
    wait_result(16);
    checkOutput("hold_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    checkOutput("idle_valid", 32'(out_valid_a), 32'd0);
    checkOutput("idle_ready", 32'(in_ready_a), 32'd1);

    $display("[TB] back-to-back 0 then 7");
    applyStimulus(16'd0);
    tick();
    binary_in = 16'd7;
    checkOutput("b2b_shift_ready", 32'(in_ready_a), 32'd0);
    wait_result(16);
    applyStimulus(16'd7);
    tick();
    in_valid = 1'b0;
    checkOutput("b2b_valid_drop", 32'(out_valid_a), 32'd0);
    checkOutput("b2b_in_shift", 32'(in_ready_a), 32'd0);
    wait_result(16);
    tick();

    $display("[TB] overflow and signed corner values");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vals[i]);
      tick();
      in_valid = 1'b0;
      wait_result(16);
      tick();
    end

    $display("[TB] backpressure in HOLD");
    out_ready = 1'b0;
    applyStimulus(16'd1000);
    tick();
    in_valid = 1'b0;
    wait_result(16);
    hold_exp = model(16'd1000, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      binary_in = 16'(i * 111 + 5);
      tick();
      checkOutput("bp_in_ready", 32'(in_ready_a), 32'd0);
      checkOutput("bp_valid", 32'(out_valid_a), 32'd1);
      checkOutput("bp_bcd", 32'(bcd_a), 32'(hold_exp.bcd));
      checkOutput("bp_nd", 32'(nd_a), 32'(hold_exp.nd));
    end
    applyStimulus(16'd4321);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("bp_accept_valid", 32'(out_valid_a), 32'd0);
    checkOutput("bp_accept_shift", 32'(in_ready_a), 32'd0);
    wait_result(16);
    tick();

    $display("[TB] reset during conversion");
    binary_in = 16'hF000;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_valid", 32'(out_valid_a), 32'd0);
    checkOutput("abort_ready", 32'(in_ready_a), 32'd1);
    checkOutput("abort_bcd", 32'(bcd_a), 32'd0);
    checkOutput("abort_nd", 32'(nd_a), 32'd0);
    checkOutput("abort_sign", 32'(sign_c), 32'd0);
    checkOutput("abort_ovf", 32'(ovf_b), 32'd0);
    applyStimulus(16'd1234);
    tick();
    in_valid = 1'b0;
    wait_result(16);
    tick();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
